// File: rtl/m_seq_checker_pkg.sv
// Shared definitions for the m-sequence checker: FSM state encoding and the
// default length/tap pairs shared with the m-sequence generator.
// Optional error/bit counters are enabled by defining MSEQ_CHK_CNT_EN; the
// default build leaves it undefined, so the counters read as zero.
package m_seq_checker_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    // Tap masks use the generator's ordering: POLY[N-1-i] selects x[t+i].
    localparam int         DEF_N     = 4;
    localparam logic [3:0] DEF_POLY  = 4'b1100;       // x[t+4] = x[t] ^ x[t+1]
    localparam int         N7        = 7;
    localparam logic [6:0] POLY7     = 7'b1100000;    // x[t+7] = x[t] ^ x[t+1]
    localparam int         N9        = 9;
    localparam logic [8:0] POLY9     = 9'b100010000;  // x[t+9] = x[t] ^ x[t+4]

endpackage

// File: rtl/m_seq_checker_lfsr_next.sv
// mseq_lfsr_next: predicts the next bit of the m-sequence from the last N
// bits, vec[0] oldest and vec[N-1] newest.
module mseq_lfsr_next #(
    parameter int           N    = 4,
    parameter logic [N-1:0] POLY = 4'b1100
) (
    input  logic [N-1:0] vec,
    output logic         pred
);

    logic [N-1:0] taps;

    // Reverse the tap mask so taps[i] selects vec[i] directly.
    for (genvar i = 0; i < N; i++) begin : g_taps
        assign taps[i] = POLY[N-1-i];
    end

    assign pred = ^(vec & taps);

endmodule

// File: rtl/m_seq_checker.sv
// m_seq_checker: self-synchronising PRBS checker. Hunts for a non-zero
// window, verifies LOCK_CNT consecutive predictions, then checks the stream
// against a free-running local LFSR and drops lock on ERR_THR errors in WIN
// bits. Define MSEQ_CHK_CNT_EN to build the err_cnt/bit_cnt counters.
module m_seq_checker
    import m_seq_checker_pkg::*;
#(
    parameter int           N        = DEF_N,
    parameter logic [N-1:0] POLY     = DEF_POLY,
    parameter int           LOCK_CNT = 8,
    parameter int           WIN      = 64,
    parameter int           ERR_THR  = 8,
    parameter int           CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_in,
    input  logic             bit_vld,
    input  logic             cnt_clr,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] bit_cnt
);

    localparam int FILL_W  = $clog2(N + 1);
    localparam int MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int WBIT_W  = $clog2(WIN + 1);
    localparam int WERR_W  = $clog2(ERR_THR + 1);

    localparam logic [FILL_W-1:0]  FILL_FULL  = FILL_W'(N);
    localparam logic [MATCH_W-1:0] MATCH_LOCK = MATCH_W'(LOCK_CNT);
    localparam logic [WBIT_W-1:0]  WIN_LAST   = WBIT_W'(WIN);
    localparam logic [WERR_W-1:0]  ERR_LIMIT  = WERR_W'(ERR_THR);

    state_t               state, state_n;
    logic [N-1:0]         w, w_n;
    logic [N-1:0]         lfsr, lfsr_n;
    logic [FILL_W-1:0]    fill, fill_n;
    logic [MATCH_W-1:0]   match, match_n;
    logic [WBIT_W-1:0]    wbit, wbit_n;
    logic [WERR_W-1:0]    werr, werr_n;
    logic                 pred_w, pred_l;
    logic                 err_ev, chk_ev;

    mseq_lfsr_next #(.N(N), .POLY(POLY)) u_pred_w (.vec(w),    .pred(pred_w));
    mseq_lfsr_next #(.N(N), .POLY(POLY)) u_pred_l (.vec(lfsr), .pred(pred_l));

    // Next-state: window shift, hunt/verify/lock sequencing, window error tally.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        state_n = state;
        w_n     = w;
        lfsr_n  = lfsr;
        fill_n  = fill;
        match_n = match;
        wbit_n  = wbit;
        werr_n  = werr;
        err_ev  = 1'b0;
        chk_ev  = 1'b0;
        if (bit_vld) begin
            // NOTE: blocking assignments here let later lines read the
            // freshly computed w_n/fill_n within the same evaluation.
            w_n = {bit_in, w[N-1:1]};
            unique case (state)
                HUNT: begin
                    if (fill != FILL_FULL) fill_n = fill + FILL_W'(1);
                    if (fill_n == FILL_FULL && w_n != '0) begin
                        state_n = VERIFY;
                        match_n = '0;
                    end
                end
                VERIFY: begin
                    if (bit_in == pred_w && w_n != '0) match_n = match + MATCH_W'(1);
                    else                               match_n = '0;
                    if (match_n == MATCH_LOCK) begin
                        state_n = LOCKED;
                        lfsr_n  = w_n;
                        wbit_n  = '0;
                        werr_n  = '0;
                    end
                end
                LOCKED: begin
                    chk_ev = 1'b1;
                    err_ev = (bit_in != pred_l);
                    lfsr_n = {pred_l, lfsr[N-1:1]};
                    if (wbit == WIN_LAST) begin
                        wbit_n = WBIT_W'(1);
                        werr_n = WERR_W'(err_ev);
                    end else begin
                        wbit_n = wbit + WBIT_W'(1);
                        werr_n = werr + WERR_W'(err_ev);
                    end
                    if (werr_n == ERR_LIMIT) begin
                        state_n = HUNT;
                        fill_n  = '0;
                        match_n = '0;
                        wbit_n  = '0;
                        werr_n  = '0;
                    end
                end
                default: state_n = HUNT;
            endcase
        end
    end

    // State and registered status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= HUNT;
            w         <= '0;
            lfsr      <= '0;
            fill      <= '0;
            match     <= '0;
            wbit      <= '0;
            werr      <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
        end else begin
            state     <= state_n;
            w         <= w_n;
            lfsr      <= lfsr_n;
            fill      <= fill_n;
            match     <= match_n;
            wbit      <= wbit_n;
            werr      <= werr_n;
            locked    <= (state_n == LOCKED);
            err_pulse <= err_ev;
        end
    end

`ifdef MSEQ_CHK_CNT_EN
    // Saturating error and bit counters; cnt_clr wins over a same-cycle event.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_cnt <= '0;
            bit_cnt <= '0;
        end else if (cnt_clr) begin
            err_cnt <= '0;
            bit_cnt <= '0;
        end else begin
            if (chk_ev && bit_cnt != '1) bit_cnt <= bit_cnt + CNT_W'(1);
            if (err_ev && err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
        end
    end
`else
    logic unused_cnt;
    assign unused_cnt = ^{cnt_clr, chk_ev};
    assign err_cnt    = '0;
    assign bit_cnt    = '0;
`endif

endmodule

// File: tb/tb_m_seq_checker.sv
// Testbench for m_seq_checker: directed test-plan phases plus a randomized
// run, all checked through a scoreboard fed by a sequence-level model.
module tb_m_seq_checker;

    localparam int           N        = 4;
    localparam logic [N-1:0] POLY     = 4'b1100;
    localparam int           LOCK_CNT = 8;
    localparam int           WIN      = 64;
    localparam int           ERR_THR  = 8;
    localparam int           CNT_W    = 16;
    localparam int           CNT_MAX  = (1 << CNT_W) - 1;
`ifdef MSEQ_CHK_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             bit_in = 1'b0;
    logic             bit_vld = 1'b0;
    logic             cnt_clr = 1'b0;
    logic             locked, err_pulse;
    logic [CNT_W-1:0] err_cnt, bit_cnt;

    m_seq_checker #(
        .N(N), .POLY(POLY), .LOCK_CNT(LOCK_CNT), .WIN(WIN),
        .ERR_THR(ERR_THR), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_vld(bit_vld),
        .cnt_clr(cnt_clr), .locked(locked), .err_pulse(err_pulse),
        .err_cnt(err_cnt), .bit_cnt(bit_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit locked;
        bit err_pulse;
        int err_cnt;
        int bit_cnt;
    } exp_t;

    exp_t  exp_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    string seq_str = "000100110101111";

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic bit sb(input int p);
        return seq_str[p % 15] == "1";
    endfunction

    // ---------------- reference model (sequence level) ----------------
    localparam int M_HUNT = 0, M_VERIFY = 1, M_LOCKED = 2;
    bit m_w[$];      // last N received valid bits, [0] oldest
    bit m_gen[$];    // last N bits of the locally regenerated sequence
    int m_state, m_fill, m_match, m_wbits, m_werrs, m_err_cnt, m_bit_cnt;

    function automatic bit recur(input bit q[$]);
        bit x = 1'b0;
        for (int i = 0; i < N; i++) x ^= q[i] & POLY[N-1-i];
        return x;
    endfunction

    function automatic bit nonzero(input bit q[$]);
        for (int i = 0; i < q.size(); i++) if (q[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_w = {};
        m_gen = {};
        for (int i = 0; i < N; i++) begin
            m_w.push_back(1'b0);
            m_gen.push_back(1'b0);
        end
        m_state = M_HUNT;
        m_fill = 0; m_match = 0; m_wbits = 0; m_werrs = 0;
        m_err_cnt = 0; m_bit_cnt = 0;
    endtask

    task automatic model_step(input bit vld, input bit b, input bit clr, output exp_t e);
        bit err, chk, pw, p;
        err = 1'b0;
        chk = 1'b0;
        if (vld) begin
            pw = recur(m_w);
            m_w.push_back(b);
            void'(m_w.pop_front());
            case (m_state)
                M_HUNT: begin
                    if (m_fill < N) m_fill++;
                    if (m_fill == N && nonzero(m_w)) begin
                        m_state = M_VERIFY;
                        m_match = 0;
                    end
                end
                M_VERIFY: begin
                    m_match = (b == pw && nonzero(m_w)) ? m_match + 1 : 0;
                    if (m_match == LOCK_CNT) begin
                        m_state = M_LOCKED;
                        m_gen = m_w;
                        m_wbits = 0;
                        m_werrs = 0;
                    end
                end
                default: begin
                    p = recur(m_gen);
                    chk = 1'b1;
                    err = (b != p);
                    m_gen.push_back(p);
                    void'(m_gen.pop_front());
                    if (m_wbits == WIN) begin
                        m_wbits = 0;
                        m_werrs = 0;
                    end
                    m_wbits++;
                    m_werrs += int'(err);
                    if (m_werrs >= ERR_THR) begin
                        m_state = M_HUNT;
                        m_fill = 0; m_match = 0; m_wbits = 0; m_werrs = 0;
                    end
                end
            endcase
        end
        if (CNT_EN) begin
            if (clr) begin
                m_err_cnt = 0;
                m_bit_cnt = 0;
            end else begin
                if (chk && m_bit_cnt < CNT_MAX) m_bit_cnt++;
                if (err && m_err_cnt < CNT_MAX) m_err_cnt++;
            end
        end
        e.locked    = (m_state == M_LOCKED);
        e.err_pulse = err;
        e.err_cnt   = m_err_cnt;
        e.bit_cnt   = m_bit_cnt;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic drive(input bit vld, input bit b, input bit clr);
        exp_t e;
        @(negedge clk);
        bit_vld = vld;
        bit_in  = b;
        cnt_clr = clr;
        model_step(vld, b, clr, e);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        bit_vld = 1'b0;
        cnt_clr = 1'b0;
        #1;
        check("rst_locked", locked, 0);
        check("rst_err_pulse", err_pulse, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_bit_cnt", bit_cnt, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sb_locked", locked, e.locked);
                check("sb_err_pulse", err_pulse, e.err_pulse);
                check("sb_err_cnt", err_cnt, e.err_cnt);
                check("sb_bit_cnt", bit_cnt, e.bit_cnt);
            end
        end
    end

    // ---------------- test sequence ----------------
    initial begin
        int pos;
        bit vld, flip, clr, b;
        int rate;

        model_reset();
        do_reset();

        // Clean stream: lock after bit 12, then 100 checked bits.
        pos = 0;
        for (int i = 1; i <= 12; i++) begin
            drive(1'b1, sb(pos), 1'b0);
            pos++;
            if (i == 11) check("lock_not_before_12", locked, 0);
        end
        check("lock_after_12", locked, 1);
        repeat (100) begin
            drive(1'b1, sb(pos), 1'b0);
            pos++;
        end
        check("bit_cnt_100", bit_cnt, CNT_EN ? 100 : 0);
        check("err_cnt_clean", err_cnt, 0);

        // Single flipped bit: one error, lock kept, no propagation.
        repeat (19) begin
            drive(1'b1, sb(pos), 1'b0);
            pos++;
        end
        drive(1'b1, !sb(pos), 1'b0);
        pos++;
        check("single_err_pulse", err_pulse, 1);
        check("single_err_cnt", err_cnt, CNT_EN ? 1 : 0);
        check("single_err_locked", locked, 1);
        repeat (30) begin
            drive(1'b1, sb(pos), 1'b0);
            pos++;
        end
        check("no_propagation_err_cnt", err_cnt, CNT_EN ? 1 : 0);
        check("no_propagation_locked", locked, 1);

        // Eight errors inside one window: loss of lock, then resync in 12 bits.
        for (int k = 0; k < 32; k++) begin
            drive(1'b1, sb(pos) ^ (k % 4 == 3), 1'b0);
            pos++;
            if (k == 27) check("locked_after_7_errs", locked, 1);
        end
        check("lol_locked", locked, 0);
        check("lol_err_pulse", err_pulse, 1);
        check("lol_err_cnt", err_cnt, CNT_EN ? 9 : 0);
        for (int i = 1; i <= 12; i++) begin
            drive(1'b1, sb(pos), 1'b0);
            pos++;
            if (i == 11) check("relock_not_before_12", locked, 0);
        end
        check("relock_after_12", locked, 1);

        // All-zero input never leaves HUNT.
        do_reset();
        repeat (50) drive(1'b1, 1'b0, 1'b0);
        check("zeros_locked", locked, 0);
        check("zeros_err_cnt", err_cnt, 0);
        check("zeros_bit_cnt", bit_cnt, 0);

        // Valid toggling: invalid cycles carry garbage that must be ignored.
        do_reset();
        pos = 0;
        for (int v = 1; v <= 12; v++) begin
            drive(1'b1, sb(pos), 1'b0);
            pos++;
            if (v == 12) check("toggle_lock_after_12", locked, 1);
            drive(1'b0, 1'($urandom_range(0, 1)), 1'b0);
            if (v == 11) check("toggle_not_before_12", locked, 0);
        end
        for (int v = 1; v <= 10; v++) begin
            drive(1'b1, sb(pos), 1'b0);
            pos++;
            drive(1'b0, 1'($urandom_range(0, 1)), 1'b0);
        end
        check("toggle_bit_cnt", bit_cnt, CNT_EN ? 10 : 0);
        check("toggle_err_cnt", err_cnt, 0);

        // cnt_clr together with an error, then reset while locked.
        drive(1'b1, !sb(pos), 1'b1);
        pos++;
        check("clr_err_pulse", err_pulse, 1);
        check("clr_err_cnt", err_cnt, 0);
        check("clr_bit_cnt", bit_cnt, 0);
        check("clr_locked", locked, 1);
        do_reset();

        // Randomized stream with bursts of errors and occasional clears.
        pos = 0;
        for (int c = 0; c < 3000; c++) begin
            rate = ((c / 200) % 3 == 2) ? 4 : 40;
            vld  = ($urandom_range(0, 3) != 0);
            flip = ($urandom_range(0, rate - 1) == 0);
            clr  = ($urandom_range(0, 199) == 0);
            if (vld) begin
                b = sb(pos) ^ flip;
                pos++;
            end else begin
                b = 1'($urandom_range(0, 1));
            end
            drive(vld, b, clr);
        end

        repeat (3) @(posedge clk);
        #2;
        check("scoreboard_drain", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/m_seq_checker.md
# m_seq_checker

Receive-side companion to the m-sequence generator. It takes a serial PN bit stream, self-synchronises a local LFSR using the same primitive-polynomial recurrence, and declares lock. Once locked, it flags and counts bit errors against the regenerated sequence. It sits at the sink end of the PRBS link-test path and feeds status and counters to the test controller.

## Interface
- N, 4, LFSR length in bits.
- POLY, 4'b1100, tap mask with the generator's bit ordering.
- LOCK_CNT, 8, consecutive correct predictions required to declare lock.
- WIN, 64, length of the loss-of-lock observation window, in valid bits.
- ERR_THR, 8, errors within one window that force loss of lock.
- CNT_W, 16, width of the error and bit counters.
- clk  input  1  single clock; everything is on the rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- bit_in  input  1  received PN bit.
- bit_vld  input  1  bit_in is valid this cycle.
- cnt_clr  input  1  synchronous clear of err_cnt and bit_cnt.
- locked  output  1  checker is in LOCKED.
- err_pulse  output  1  one-cycle pulse: the last valid bit mismatched while LOCKED.
- err_cnt  output  CNT_W  saturating count of errors seen while LOCKED.
- bit_cnt  output  CNT_W  saturating count of valid bits checked while LOCKED.

## Operation
- Recurrence: x[t+N] = XOR over i of (x[t+i] & POLY[N-1-i]). With the defaults this is x[t+4] = x[t] ^ x[t+1], period 15: 000100110101111.
- Receive window w[N-1:0]:
  - Every valid bit shifts in, newest into w[N-1] and oldest out of w[0], in every state.
  - Prediction for the next bit = the recurrence applied to w.
- HUNT (reset state):
  - A fill counter counts valid bits, saturating at N.
  - Move to VERIFY once fill = N and w is non-zero.
- VERIFY:
  - Each valid bit is compared with the prediction made from w before the shift.
  - A match increments match_cnt; a mismatch clears it.
  - An all-zero w after the shift clears match_cnt.
  - When match_cnt reaches LOCK_CNT: load the local LFSR with the post-shift w and move to LOCKED.
- LOCKED:
  - The local LFSR advances only on valid bits and no longer loads from w, so received errors do not propagate.
  - A mismatch between bit_in and the LFSR's predicted bit pulses err_pulse and increments the window error count.
  - The window bit count runs 1..WIN and then restarts; the window error count clears at each restart.
  - If the window error count reaches ERR_THR: move to HUNT, clear the fill, match and window counts, and deassert locked.
- Counters:
  - err_cnt and bit_cnt advance only in LOCKED and saturate at all-ones.
  - cnt_clr has priority: an event in the same cycle is not counted, though err_pulse still fires.
- bit_vld = 0: no state, window, LFSR or counter changes, and err_pulse = 0.

## Timing
- Reset values: locked = 0, err_pulse = 0, err_cnt = 0, bit_cnt = 0, state = HUNT, w = 0, LFSR = 0.
- All outputs are registered.
  - err_pulse, locked and the counters update in the cycle after the sampling edge of the relevant bit_vld.
  - This gives 1-cycle latency.
- Clean continuous stream after reset:
  - Bits 1–4 fill w.
  - Bits 5–12 give 8 matches.
  - locked is high from the cycle after bit 12 is sampled.
- Loss of lock:
  - locked falls in the same cycle that err_pulse shows the ERR_THR-th error.
  - That bit is counted in err_cnt.
- Reset asserted mid-operation returns every output and state to its reset value immediately, without waiting for a clock edge.

## Configuration
- MSEQ_CHK_CNT_EN defined: err_cnt, bit_cnt and the cnt_clr logic are implemented as described.
- Not defined:
  - err_cnt and bit_cnt are tied to 0 and cnt_clr is ignored.
  - locked and err_pulse behave identically.

## Structure
- define.v holds the shared items:
  - state encodings: HUNT = 2'd0, VERIFY = 2'd1, LOCKED = 2'd2;
  - the MSEQ_CHK_CNT_EN default;
  - the default N/POLY pairs shared with the generator.
- One combinational sub-module, mseq_lfsr_next (N, POLY).
  - It computes the predicted bit from an N-bit vector.
  - It is instantiated twice: once for w, once for the local LFSR.

## Test plan
- Clean stream 000100110101111 repeated, bit_vld = 1 continuously:
  - locked rises the cycle after bit 12;
  - err_pulse never fires;
  - after 100 further bits, bit_cnt = 100 and err_cnt = 0.
- Locked, then bit 20 of the locked stream is flipped: one err_pulse, err_cnt = 1, locked stays 1, and the next bits check clean (no error propagation).
- Locked, then 8 flipped bits within 64: locked drops with the 8th err_pulse; after a clean resync, locked returns 12 bits later.
- All-zero input for 50 bits after reset: stays in HUNT, locked = 0, counters = 0.
- bit_vld toggling 1/0 on a clean stream: lock after 12 valid bits; the invalid cycles do not advance the LFSR or counters.
- cnt_clr asserted together with an error: err_cnt = 0 and err_pulse = 1. Reset asserted while locked: all outputs 0 immediately.
